// File: rtl/sc_multispeed_tickgen.sv
// Multi-channel speed tick generator: per-channel free-running period counters
// whose periods shrink together with a shared saturating game level.

module sc_multispeed_chan #(
  parameter int DATAWIDTH = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pause,
  input  logic                 clr,
  input  logic [DATAWIDTH-1:0] period,
  output logic [DATAWIDTH-1:0] count,
  output logic                 tick
);
  // '>=' rather than '==' so a period shortened mid-count wraps at once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (pause) begin
      tick  <= 1'b0;
    end else if (count >= period - DATAWIDTH'(1)) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + DATAWIDTH'(1);
      tick  <= 1'b0;
    end
  end
endmodule

module sc_multispeed_tickgen #(
  parameter int DATAWIDTH   = 27,
  parameter int CHANNELS    = 4,
  parameter int LEVELWIDTH  = 3,
  parameter int MAX_LEVEL   = 7,
  parameter int BASE_PERIOD = 50_000_000,
  parameter int MIN_PERIOD  = 1000
) (
  input  logic                          SC_MULTISPEED_CLOCK_50,
  input  logic                          SC_MULTISPEED_RESET_InLow,
  input  logic [CHANNELS-1:0]           SC_MULTISPEED_upcount_InLow,
  input  logic [CHANNELS-1:0]           SC_MULTISPEED_clear_InHigh,
  input  logic                          SC_MULTISPEED_levelup_InHigh,
  input  logic                          SC_MULTISPEED_levelreset_InHigh,
  output logic [CHANNELS-1:0]           SC_MULTISPEED_tick_OutBUS,
  output logic [CHANNELS*DATAWIDTH-1:0] SC_MULTISPEED_data_OutBUS,
  output logic [LEVELWIDTH-1:0]         SC_MULTISPEED_level_OutBUS,
  output logic                          SC_MULTISPEED_maxlevel_OutHigh
);
  localparam logic [DATAWIDTH-1:0]  BASE    = DATAWIDTH'(BASE_PERIOD);
  localparam logic [DATAWIDTH-1:0]  PMIN    = DATAWIDTH'(MIN_PERIOD);
  localparam logic [LEVELWIDTH-1:0] LVL_MAX = LEVELWIDTH'(MAX_LEVEL);

  logic [LEVELWIDTH-1:0]                level;
  logic [CHANNELS-1:0][DATAWIDTH-1:0]   cnt;
  logic [CHANNELS-1:0]                  tick;

  always_ff @(posedge SC_MULTISPEED_CLOCK_50) begin
    if (!SC_MULTISPEED_RESET_InLow)
      level <= '0;
    else if (SC_MULTISPEED_levelreset_InHigh)
      level <= '0;
    else if (SC_MULTISPEED_levelup_InHigh && level < LVL_MAX)
      level <= level + LEVELWIDTH'(1);
  end

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic [31:0]          sh;
      logic [DATAWIDTH-1:0] shifted;
      logic [DATAWIDTH-1:0] period;

      // Oversized shifts yield 0, which the floor then lifts to PMIN
      assign sh      = 32'(level) + 32'(c);
      assign shifted = BASE >> sh;
      assign period  = (shifted > PMIN) ? shifted : PMIN;

      sc_multispeed_chan #(.DATAWIDTH(DATAWIDTH)) u_chan (
        .clk    (SC_MULTISPEED_CLOCK_50),
        .rst_n  (SC_MULTISPEED_RESET_InLow),
        .pause  (SC_MULTISPEED_upcount_InLow[c]),
        .clr    (SC_MULTISPEED_clear_InHigh[c]),
        .period (period),
        .count  (cnt[c]),
        .tick   (tick[c])
      );
    end
  endgenerate

  assign SC_MULTISPEED_data_OutBUS      = cnt;
  assign SC_MULTISPEED_tick_OutBUS      = tick;
  assign SC_MULTISPEED_level_OutBUS     = level;
  assign SC_MULTISPEED_maxlevel_OutHigh = (level == LVL_MAX);
endmodule

// File: tb/tb_sc_multispeed_tickgen.sv
// Randomized + directed bench for sc_multispeed_tickgen with a queue scoreboard
// against an arithmetic reference model.

module tb_sc_multispeed_tickgen;
  localparam int DW = 8, CH = 2, LW = 2, MAXL = 3, BASE = 16, PMIN = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH-1:0]     up_n = '0;
  logic [CH-1:0]     clr = '0;
  logic              lvup = 1'b0;
  logic              lvrst = 1'b0;
  logic [CH-1:0]     tick;
  logic [CH*DW-1:0]  data;
  logic [LW-1:0]     level;
  logic              maxl;

  sc_multispeed_tickgen #(
    .DATAWIDTH(DW), .CHANNELS(CH), .LEVELWIDTH(LW), .MAX_LEVEL(MAXL),
    .BASE_PERIOD(BASE), .MIN_PERIOD(PMIN)
  ) dut (
    .SC_MULTISPEED_CLOCK_50          (clk),
    .SC_MULTISPEED_RESET_InLow       (rst_n),
    .SC_MULTISPEED_upcount_InLow     (up_n),
    .SC_MULTISPEED_clear_InHigh      (clr),
    .SC_MULTISPEED_levelup_InHigh    (lvup),
    .SC_MULTISPEED_levelreset_InHigh (lvrst),
    .SC_MULTISPEED_tick_OutBUS       (tick),
    .SC_MULTISPEED_data_OutBUS       (data),
    .SC_MULTISPEED_level_OutBUS      (level),
    .SC_MULTISPEED_maxlevel_OutHigh  (maxl)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt [CH];
    bit tk  [CH];
    int lvl;
    bit mx;
  } exp_t;

  exp_t exp_q[$];
  int   errs = 0, checks = 0, ticks_seen = 0;

  // reference model state
  int m_cnt [CH];
  bit m_tk  [CH];
  int m_lvl = 0;

  function automatic int period_of(int l, int c);
    int p;
    p = BASE / (1 << (l + c));
    return (p < PMIN) ? PMIN : p;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic step(input bit r, input bit [CH-1:0] u, input bit [CH-1:0] cl,
                      input bit lu, input bit lr);
    exp_t e;
    @(negedge clk);
    rst_n = r; up_n = u; clr = cl; lvup = lu; lvrst = lr;
    for (int c = 0; c < CH; c++) begin
      if (!r || cl[c]) begin
        m_cnt[c] = 0; m_tk[c] = 0;
      end else if (u[c]) begin
        m_tk[c] = 0;
      end else if (m_cnt[c] + 1 >= period_of(m_lvl, c)) begin
        m_cnt[c] = 0; m_tk[c] = 1;
      end else begin
        m_cnt[c]++; m_tk[c] = 0;
      end
    end
    if (!r || lr) m_lvl = 0;
    else if (lu && m_lvl < MAXL) m_lvl++;
    e.cnt = m_cnt; e.tk = m_tk; e.lvl = m_lvl; e.mx = (m_lvl == MAXL);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input bit [CH-1:0] u);
    for (int i = 0; i < n; i++) step(1, u, 2'b00, 0, 0);
  endtask

  // monitor: compare every registered update against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int c = 0; c < CH; c++) begin
          chk($sformatf("data_ch%0d", c), int'(data[c*DW +: DW]), e.cnt[c]);
          chk($sformatf("tick_ch%0d", c), int'(tick[c]), int'(e.tk[c]));
          if (tick[c]) ticks_seen++;
        end
        chk("level", int'(level), e.lvl);
        chk("maxlevel", int'(maxl), int'(e.mx));
      end
    end
  end

  initial begin
    // reset held two clocks while other inputs toggle
    step(0, 2'b11, 2'b10, 1, 0);
    step(0, 2'b00, 2'b01, 1, 1);
    // both channels run from 0 at level 0
    run(40, 2'b00);
    // level ramps to saturation while running
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b00, 2'b00, 1, 0);
      run(3, 2'b00);
    end
    run(8, 2'b00);
    // pause ch0 at count 7, then resume
    step(0, 2'b00, 2'b00, 0, 0);
    run(7, 2'b00);
    run(5, 2'b01);
    run(12, 2'b00);
    // level rise while ch0 count already beyond new period
    step(0, 2'b00, 2'b00, 0, 0);
    run(12, 2'b00);
    step(1, 2'b00, 2'b00, 1, 0);
    run(4, 2'b00);
    // clear beats run; levelreset beats levelup
    step(1, 2'b00, 2'b10, 0, 0);
    step(1, 2'b00, 2'b00, 1, 1);
    // reset mid-count at count 10, then restart
    step(0, 2'b00, 2'b00, 0, 0);
    run(10, 2'b00);
    step(0, 2'b00, 2'b00, 1, 0);
    run(20, 2'b00);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit [CH-1:0] u, cl;
      for (int c = 0; c < CH; c++) begin
        u[c]  = ($urandom_range(0, 3) == 0);
        cl[c] = ($urandom_range(0, 15) == 0);
      end
      step($urandom_range(0, 99) != 0, u, cl,
           $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
    end
    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (ticks_seen == 0) begin
      errs++;
      $display("FAIL tick_activity: got %0d ticks expected >0", ticks_seen);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
